// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / load-store bus controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IFETCH,
        DACCESS
    } fetch_state_t;

    localparam logic [3:0]  SEL_WORD        = 4'hF;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for outstanding bus transactions; expire is high in the
// LIMIT-th consecutive counting cycle since the last load.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    // At least 8 bits, wider if LIMIT needs it.
    localparam int unsigned CW = ($clog2(LIMIT + 1) < 8) ? 8 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expire = count && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt_q <= '0;
        end else if (count && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Arbitrates instruction fetches and load/stores onto one shared memory bus.
// Optional FETCH_TIMEOUT_EN adds a no-ack abort with a bus_timeout pulse.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    input  logic              bus_busy,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] instr_data,
    output logic              freeze_instr,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              bus_timeout
`endif
);

    fetch_state_t      state_q, state_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic in_flight;
    logic expire;
    logic ack_fetch;
    logic ack_data;

    assign in_flight = (state_q != IDLE);
    assign ack_fetch = (state_q == IFETCH) && bus_ack;
    assign ack_data  = (state_q == DACCESS) && bus_ack;

`ifdef FETCH_TIMEOUT_EN
    // Held in load while idle, so every launch starts from zero.
    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (!in_flight),
        .count  (in_flight && !bus_ack),
        .expire (expire)
    );
    assign bus_timeout = expire;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Data access first: it belongs to the already-fetched instruction.
                if (!bus_busy && (d_read || d_write)) begin
                    state_d = DACCESS;
                    write_d = d_write;
                    read_d  = !d_write;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    sel_d   = d_sel;
                end else if (!bus_busy && fetch_en) begin
                    state_d = IFETCH;
                    read_d  = 1'b1;
                    write_d = 1'b0;
                    addr_d  = pc;
                    sel_d   = SEL_WORD;
                end
            end
            IFETCH, DACCESS: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (state_q == IFETCH) begin
                        instr_d = bus_rdata;
                    end else if (read_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            instr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_read     = read_q;
    assign bus_write    = write_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_sel      = sel_q;
    // The holder captures the word combinationally in the ack cycle.
    assign instr_data   = ack_fetch ? bus_rdata : instr_q;
    assign freeze_instr = !ack_fetch;
    assign d_done       = ack_data;
    assign d_rdata      = (ack_data && read_q) ? bus_rdata : rdata_q;
    assign stall        = in_flight ? !bus_ack
                                    : (bus_busy && (fetch_en || d_read || d_write));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, d_addr, d_wdata, bus_rdata;
    logic        fetch_en, d_read, d_write, bus_busy, bus_ack;
    logic [3:0]  d_sel;
    logic        bus_read, bus_write, freeze_instr, d_done, stall;
    logic [31:0] bus_addr, bus_wdata, instr_data, d_rdata;
    logic [3:0]  bus_sel;
`ifdef FETCH_TIMEOUT_EN
    logic        bus_timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_sel        (d_sel),
        .bus_busy     (bus_busy),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_sel      (bus_sel),
        .instr_data   (instr_data),
        .freeze_instr (freeze_instr),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .stall        (stall)
`ifdef FETCH_TIMEOUT_EN
        ,
        .bus_timeout  (bus_timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, got, exp);
        end
    endtask

    // Transaction-level model: one outstanding transaction and its latched request.
    bit          m_busy, m_fetch, m_wr;
    logic [31:0] m_addr, m_wdata, m_instr, m_load;
    logic [3:0]  m_sel;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_fetch <= 0; m_wr <= 0;
            m_addr <= 0; m_wdata <= 0; m_sel <= 0; m_instr <= 0; m_load <= 0;
        end else if (m_busy) begin
            if (bus_ack) begin
                m_busy <= 0;
                if (m_fetch) m_instr <= bus_rdata;
                else if (!m_wr) m_load <= bus_rdata;
            end
        end else if (!bus_busy && (d_read || d_write)) begin
            m_busy <= 1; m_fetch <= 0; m_wr <= d_write;
            m_addr <= d_addr; m_wdata <= d_wdata; m_sel <= d_sel;
        end else if (!bus_busy && fetch_en) begin
            m_busy <= 1; m_fetch <= 1; m_wr <= 0;
            m_addr <= pc; m_sel <= 4'hF;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit acked = m_busy && bus_ack;
            automatic bit got_instr = acked && m_fetch;
            automatic bit done = acked && !m_fetch;
            cmp("m_bus_read", 32'(bus_read), 32'(m_busy && !m_wr));
            cmp("m_bus_write", 32'(bus_write), 32'(m_busy && m_wr));
            cmp("m_bus_addr", bus_addr, m_addr);
            cmp("m_bus_wdata", bus_wdata, m_wdata);
            cmp("m_bus_sel", 32'(bus_sel), 32'(m_sel));
            cmp("m_instr_data", instr_data, got_instr ? bus_rdata : m_instr);
            cmp("m_freeze", 32'(freeze_instr), 32'(!got_instr));
            cmp("m_d_done", 32'(d_done), 32'(done));
            cmp("m_d_rdata", d_rdata, (done && !m_wr) ? bus_rdata : m_load);
            cmp("m_stall", 32'(stall),
                32'(m_busy ? !bus_ack : (bus_busy && (fetch_en || d_read || d_write))));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; pc = 0; fetch_en = 0; d_read = 0; d_write = 0; d_addr = 0;
        d_wdata = 0; d_sel = 0; bus_busy = 0; bus_ack = 0; bus_rdata = 0;
        step(); step();
        chk_en = 1;
        rst = 0;
        @(negedge clk);
        cmp("rst_freeze", 32'(freeze_instr), 32'd1);
        cmp("rst_instr", instr_data, 32'h0);
        cmp("rst_bus_read", 32'(bus_read), 32'd0);

        // Fetch with ack in the third request cycle
        #1; fetch_en = 1; pc = 32'h100;
        step(); fetch_en = 0;
        @(negedge clk);
        cmp("f1_read", 32'(bus_read), 32'd1);
        cmp("f1_addr", bus_addr, 32'h100);
        cmp("f1_sel", 32'(bus_sel), 32'hF);
        cmp("f1_stall", 32'(stall), 32'd1);
        step();
        step(); bus_ack = 1; bus_rdata = 32'h0050_0093;
        @(negedge clk);
        cmp("f1_ack_read", 32'(bus_read), 32'd1);
        cmp("f1_ack_freeze", 32'(freeze_instr), 32'd0);
        cmp("f1_ack_instr", instr_data, 32'h0050_0093);
        cmp("f1_ack_stall", 32'(stall), 32'd0);
        step(); bus_ack = 0; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        cmp("f1_post_read", 32'(bus_read), 32'd0);
        cmp("f1_post_freeze", 32'(freeze_instr), 32'd1);
        cmp("f1_post_instr", instr_data, 32'h0050_0093);

        // Simultaneous fetch and load: load wins, then fetch
        #1; fetch_en = 1; d_read = 1; d_addr = 32'h2000; pc = 32'h104;
        step(); d_read = 0; bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        cmp("ld_addr", bus_addr, 32'h2000);
        cmp("ld_read", 32'(bus_read), 32'd1);
        cmp("ld_done", 32'(d_done), 32'd1);
        cmp("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        cmp("ld_freeze", 32'(freeze_instr), 32'd1);
        step(); bus_ack = 0; bus_rdata = 0;
        @(negedge clk);
        cmp("ld_done_off", 32'(d_done), 32'd0);
        cmp("ld_rdata_held", d_rdata, 32'hDEAD_BEEF);
        step(); fetch_en = 0; bus_ack = 1; bus_rdata = 32'h0010_0073;
        @(negedge clk);
        cmp("f2_addr", bus_addr, 32'h104);
        cmp("f2_instr", instr_data, 32'h0010_0073);
        step(); bus_ack = 0;

        // Store held off by a busy bus for four cycles
        d_write = 1; d_wdata = 32'h1234_5678; d_sel = 4'b0011; d_addr = 32'h3000;
        bus_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp("busy_stall", 32'(stall), 32'd1);
            cmp("busy_no_write", 32'(bus_write), 32'd0);
            step();
        end
        bus_busy = 0;
        step(); d_write = 0; d_wdata = 32'hFFFF_FFFF; d_sel = 4'h0; d_addr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmp("st_write", 32'(bus_write), 32'd1);
            cmp("st_wdata", bus_wdata, 32'h1234_5678);
            cmp("st_sel", 32'(bus_sel), 32'h3);
            cmp("st_addr", bus_addr, 32'h3000);
            step();
        end
        bus_ack = 1;
        @(negedge clk);
        cmp("st_done", 32'(d_done), 32'd1);
        cmp("st_rdata_keep", d_rdata, 32'hDEAD_BEEF);
        step(); bus_ack = 0;

        // Read and write together: write performed
        d_read = 1; d_write = 1; d_addr = 32'h4000; d_wdata = 32'hA5A5_0001; d_sel = 4'hC;
        step(); d_read = 0; d_write = 0;
        @(negedge clk);
        cmp("rw_write", 32'(bus_write), 32'd1);
        cmp("rw_no_read", 32'(bus_read), 32'd0);
        cmp("rw_addr", bus_addr, 32'h4000);
        bus_ack = 1; bus_rdata = 32'h7777_7777;
        step(); bus_ack = 0;

        // Reset two cycles into a fetch; the late ack must be ignored
        fetch_en = 1; pc = 32'h200;
        step(); fetch_en = 0;
        step(); rst = 1;
        step(); rst = 0; bus_ack = 1; bus_rdata = 32'h0000_0BAD;
        @(negedge clk);
        cmp("rs_read", 32'(bus_read), 32'd0);
        cmp("rs_addr", bus_addr, 32'h0);
        cmp("rs_sel", 32'(bus_sel), 32'h0);
        cmp("rs_instr", instr_data, 32'h0);
        cmp("rs_freeze", 32'(freeze_instr), 32'd1);
        cmp("rs_stall", 32'(stall), 32'd0);
        cmp("rs_rdata", d_rdata, 32'h0);
        step(); bus_ack = 0;
        @(negedge clk);
        cmp("rs_instr_after", instr_data, 32'h0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
